// File: rtl/snn_pkg.sv
// Shared definitions for the SNN memory blocks: default geometry of the
// word memory and the burst reader FSM state encoding.
package snn_pkg;

  localparam int SNN_M  = 320;
  localparam int SNN_N  = 8;
  localparam int SNN_AW = 9;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_FETCH  = 2'd1;
  localparam logic [ST_W-1:0] ST_SEND   = 2'd2;
  localparam logic [ST_W-1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/memory_reader_addr_wrap_inc.sv
// Address incrementer for an M-word memory: steps to the next word and
// wraps from the top word back to word 0.
module addr_wrap_inc #(
  parameter int AW = 9,
  parameter int M  = 320
) (
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr
);

  // >= rather than == so a stray out-of-range address also recovers to 0
  always_comb begin
    if (addr >= AW'(M - 1)) begin
      next_addr = '0;
    end else begin
      next_addr = addr + 1'b1;
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Burst reader: walks a wrapping address range of a combinational-read
// memory and streams the words downstream over a valid/ready port.
module memory_reader
  import snn_pkg::*;
#(
  parameter int M  = SNN_M,
  parameter int N  = SNN_N,
  parameter int AW = SNN_AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic [AW-1:0]   length,
  output logic [AW-1:0]   mem_addr,
  input  logic [N-1:0]    mem_data,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ST_W-1:0] state_dbg
);

  // Handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low,
  // out_data, out_last and mem_addr hold their values.

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_next;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_inc;
  logic [AW-1:0]   count_q;
  logic [N-1:0]    data_q;
  logic            err_q;

  logic start_in_range;
  logic start_accept;
  logic start_empty;
  logic start_reject;
  logic last_word;
  logic handshake;

  addr_wrap_inc #(
    .AW (AW),
    .M  (M)
  ) u_addr_wrap_inc (
    .addr      (addr_q),
    .next_addr (addr_inc)
  );

  // Widened by one bit so M == 2**AW still compares correctly
  assign start_in_range = ({1'b0, start_addr} < (AW + 1)'(M));

  assign start_reject = (state == ST_IDLE) && start && !start_in_range;
  assign start_empty  = (state == ST_IDLE) && start && start_in_range && (length == '0);
  assign start_accept = (state == ST_IDLE) && start && start_in_range && (length != '0);

  assign last_word = (count_q == AW'(1));
  assign handshake = (state == ST_SEND) && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_accept) begin
          state_next = ST_FETCH;
        end else if (start_empty) begin
          state_next = ST_FINISH;
        end
      end
      ST_FETCH: begin
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          state_next = last_word ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address stays on the final word after the last handshake so mem_addr
  // keeps its last value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (start_accept) begin
      addr_q  <= start_addr;
      count_q <= length;
    end else if (handshake) begin
      count_q <= count_q - 1'b1;
      if (!last_word) begin
        addr_q <= addr_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (state == ST_FETCH) begin
      data_q <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= start_reject;
    end
  end

  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = (state == ST_SEND);
  assign out_last  = (state == ST_SEND) && last_word;
  assign busy      = (state == ST_FETCH) || (state == ST_SEND);
  assign done      = (state == ST_FINISH);
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: burst timing, wrap, backpressure,
// empty and rejected starts, ignored starts and mid-burst reset.
module tb_memory_reader;
  import snn_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [8:0] start_addr;
  logic [8:0] length;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [320];
  logic [7:0] exp_q [$];
  logic [8:0] exp_addr_q [$];

  memory_reader #(
    .M  (320),
    .N  (8),
    .AW (9)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 320; i++) mem[i] = 8'(i * 3 + 1);
  end

  always_comb begin
    mem_data = (mem_addr < 9'd320) ? mem[mem_addr] : 8'h00;
  end

  // driver tasks
  task automatic do_start(input logic [8:0] a, input logic [8:0] l, input bit sync);
    if (sync) begin
      @(posedge clk);
      #1;
    end
    start      = 1'b1;
    start_addr = a;
    length     = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams one burst, checking every presented word against exp_q/exp_addr_q.
  task automatic run_burst(input logic [8:0] a, input logic [8:0] l, input bit sync,
                           input int stall_word, input int stall_n, input int inject_at,
                           input string name);
    int  k;
    int  stalls;
    bit  seen_done;
    k = 0;
    stalls = 0;
    seen_done = 1'b0;
    out_ready = 1'b1;
    do_start(a, l, sync);
    for (int c = 1; c <= 200 && !seen_done; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        start = 1'b1;
        start_addr = 9'd200;
        length = 9'd2;
      end else begin
        start = 1'b0;
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL %s err: got %b want 0 (cycle %0d)", name, err, c);
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s extra_word: got %0d want none", name, out_data);
        end else begin
          total += 3;
          if (out_data !== exp_q[0]) begin
            bad++;
            $display("FAIL %s data[%0d]: got %0d want %0d", name, k, out_data, exp_q[0]);
          end
          if (mem_addr !== exp_addr_q[0]) begin
            bad++;
            $display("FAIL %s addr[%0d]: got %0d want %0d", name, k, mem_addr, exp_addr_q[0]);
          end
          if (out_last !== (exp_q.size() == 1)) begin
            bad++;
            $display("FAIL %s last[%0d]: got %b want %b", name, k, out_last, exp_q.size() == 1);
          end
          if (k == stall_word && stalls < stall_n) begin
            out_ready = 1'b0;
            stalls++;
          end else begin
            out_ready = 1'b1;
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
            k++;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s done_cycle: got valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL %s timeout: got no done want done within 200 cycles", name);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s words_left: got %0d want 0", name, exp_q.size());
    end
    if (stall_n > 0) begin
      total++;
      if (stalls != stall_n) begin
        bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, stall_n);
      end
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({mem_addr, out_data, out_valid, out_last, busy, done, err, state_dbg} !== '0) begin
      bad++;
      $display("FAIL %s outputs: got addr=%0d data=%0d v=%b l=%b busy=%b done=%b err=%b st=%0d want all 0",
               name, mem_addr, out_data, out_valid, out_last, busy, done, err, state_dbg);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    out_ready = 1'b1;
    #3;
    check_all_zero("reset");
    total++;
    if (state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset state: got %0d want %0d", state_dbg, ST_IDLE);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] ev = 8'b0010_1010;
    logic [7:0] el = 8'b0010_0000;
    logic [7:0] ed = 8'b0100_0000;
    logic [7:0] eb = 8'b0011_1111;
    logic [8:0] ea [8] = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd7, 9'd7, 9'd7, 9'd7};
    logic [7:0] ew [8] = '{8'd0, 8'd16, 8'd0, 8'd19, 8'd0, 8'd22, 8'd0, 8'd0};
    out_ready = 1'b1;
    do_start(9'd5, 9'd3, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total += 5;
      if (out_valid !== ev[c]) begin
        bad++;
        $display("FAIL basic valid c%0d: got %b want %b", c + 1, out_valid, ev[c]);
      end
      if (out_last !== el[c]) begin
        bad++;
        $display("FAIL basic last c%0d: got %b want %b", c + 1, out_last, el[c]);
      end
      if (done !== ed[c]) begin
        bad++;
        $display("FAIL basic done c%0d: got %b want %b", c + 1, done, ed[c]);
      end
      if (busy !== eb[c]) begin
        bad++;
        $display("FAIL basic busy c%0d: got %b want %b", c + 1, busy, eb[c]);
      end
      if (mem_addr !== ea[c]) begin
        bad++;
        $display("FAIL basic addr c%0d: got %0d want %0d", c + 1, mem_addr, ea[c]);
      end
      if (ev[c]) begin
        total++;
        if (out_data !== ew[c]) begin
          bad++;
          $display("FAIL basic data c%0d: got %0d want %0d", c + 1, out_data, ew[c]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    do_start(9'd20, 9'd0, 1'b1);
    @(negedge clk);
    total++;
    if ({done, out_valid, busy, err} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_len c1: got done/valid/busy/err=%b%b%b%b want 1000", done, out_valid, busy, err);
    end
    @(negedge clk);
    total++;
    if ({done, out_valid, busy, err} !== 4'b0000) begin
      bad++;
      $display("FAIL zero_len c2: got done/valid/busy/err=%b%b%b%b want 0000", done, out_valid, busy, err);
    end
  endtask

  task automatic test_err();
    do_start(9'd320, 9'd3, 1'b1);
    @(negedge clk);
    total += 2;
    if ({err, busy, done, out_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL err c1: got err/busy/done/valid=%b%b%b%b want 1000", err, busy, done, out_valid);
    end
    if (mem_addr !== 9'd7) begin
      bad++;
      $display("FAIL err addr_hold: got %0d want 7", mem_addr);
    end
    @(negedge clk);
    total++;
    if ({err, busy, done, out_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL err c2: got err/busy/done/valid=%b%b%b%b want 0000", err, busy, done, out_valid);
    end
  endtask

  task automatic test_wrap();
    exp_q = '{8'd187, 8'd190, 8'd1, 8'd4};
    exp_addr_q = '{9'd318, 9'd319, 9'd0, 9'd1};
    run_burst(9'd318, 9'd4, 1'b1, -1, 0, -1, "wrap");
  endtask

  task automatic test_stall();
    exp_q = '{8'd31, 8'd34, 8'd37};
    exp_addr_q = '{9'd10, 9'd11, 9'd12};
    run_burst(9'd10, 9'd3, 1'b1, 1, 5, -1, "stall");
  endtask

  task automatic test_ignore_start();
    exp_q = '{8'd45, 8'd48, 8'd51, 8'd54};
    exp_addr_q = '{9'd100, 9'd101, 9'd102, 9'd103};
    run_burst(9'd100, 9'd4, 1'b1, -1, 0, 3, "ignore");
    repeat (2) @(negedge clk);
    total++;
    if ({busy, err, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL ignore after: got busy/err/valid=%b%b%b want 000", busy, err, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    do_start(9'd50, 9'd5, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid pre: got valid=%b want 1", out_valid);
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q = '{8'd181, 8'd184};
    exp_addr_q = '{9'd60, 9'd61};
    run_burst(9'd60, 9'd2, 1'b0, -1, 0, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_err();
    test_wrap();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
